// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int unsigned LEN_W          = 16;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

   function automatic logic is_busy(input state_e s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Byte-gap watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT.
module loader_timeout_counter #(
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Asserted one cycle early so the owner's registered state lands exactly on TIMEOUT.
   assign expired = enable && !clear && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed byte stream and writes it
// word by word into instruction memory while holding the CPU via busy.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        error
);

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   word_idx_q, word_idx_d;
   logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0]        asm_q, asm_d;
   logic [7:0]         csum_q, csum_d;
   logic               wr_en_q, wr_en_d;
   logic [31:0]        wr_addr_q, wr_addr_d;
   logic [31:0]        wr_data_q, wr_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;

   logic               in_session;
   logic               start_go;
   logic               accept;
   logic               expired;
   logic [LEN_W-1:0]   len_rx;

   assign in_session = is_busy(state_q);
   assign start_go   = start && !in_session;
   assign accept     = rx_valid && in_session;
   assign len_rx     = {len_q[LEN_W-1:8], rx_data};

   loader_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_gap (
      .clk     (clk),
      .reset   (reset),
      .clear   (start_go || accept),
      .enable  (in_session),
      .expired (expired)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      csum_d     = csum_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = done_q;
      error_d    = error_q;

      if (start_go) begin
         state_d    = ST_LEN_HI;
         done_d     = 1'b0;
         error_d    = 1'b0;
         csum_d     = '0;
         word_idx_d = '0;
         byte_cnt_d = '0;
      end else if (accept) begin
         unique case (state_q)
            ST_LEN_HI: begin
               len_d   = {rx_data, len_q[7:0]};
               state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               len_d = len_rx;
               if ((len_rx == '0) || (len_rx > LEN_W'(DEPTH))) begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               csum_d     = csum_q ^ rx_data;
               byte_cnt_d = byte_cnt_q + 1'b1;
               asm_d      = {asm_q[15:0], rx_data};
               if (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = {word_idx_q, 2'b00};
                  wr_data_d  = {asm_q, rx_data};
                  word_idx_d = word_idx_q + 1'b1;
                  if (word_idx_q == len_q - 1'b1) state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (rx_data == csum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
               end
            end
            default: ;
         endcase
      end else if (expired) begin
         state_d    = ST_ERR;
         error_d    = 1'b1;
         byte_cnt_d = '0;
      end

      busy_d = is_busy(state_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         word_idx_q <= '0;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         csum_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         csum_q     <= csum_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

   localparam int unsigned TB_DEPTH   = 256;
   localparam int unsigned TB_TIMEOUT = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;

   int cmp_cnt = 0;
   int err_cnt = 0;

   logic [31:0] cap_addr[$];
   logic [31:0] cap_data[$];

   imem_loader #(
      .DEPTH   (TB_DEPTH),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         cap_addr.push_back(wr_addr);
         cap_data.push_back(wr_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      cmp_cnt++;
      if ({wr_en, wr_addr, wr_data, busy, done, error} !== 68'd0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b err=%b, want all 0",
                  wr_en, wr_addr, wr_data, busy, done, error);
      end
   endtask

   task automatic test_good_load();
      int base;
      base = cap_addr.size();
      pulse_start();
      cmp_cnt++;
      if (busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL good_busy_start: got %b want 1", busy);
      end
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h3C); send_byte(8'h0D); send_byte(8'h40); send_byte(8'h00);
      cmp_cnt++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 32'h0, 32'h3C0D4000}) begin
         err_cnt++;
         $display("FAIL good_word0_timing: got en=%b addr=%h data=%h want en=1 addr=0 data=3c0d4000",
                  wr_en, wr_addr, wr_data);
      end
      send_byte(8'hAD);
      cmp_cnt++;
      if (wr_en !== 1'b0) begin
         err_cnt++;
         $display("FAIL good_wr_en_one_cycle: got %b want 0", wr_en);
      end
      send_byte(8'hA0); send_byte(8'h00); send_byte(8'h08);
      send_byte(8'h74);
      cmp_cnt++;
      if (cap_addr.size() - base != 2) begin
         err_cnt++;
         $display("FAIL good_write_count: got %0d want 2", cap_addr.size() - base);
      end else begin
         cmp_cnt++;
         if ({cap_addr[base+1], cap_data[base+1]} !== {32'h4, 32'hADA00008}) begin
            err_cnt++;
            $display("FAIL good_word1: got addr=%h data=%h want 4 ada00008",
                     cap_addr[base+1], cap_data[base+1]);
         end
      end
      cmp_cnt++;
      if ({done, error, busy} !== 3'b100) begin
         err_cnt++;
         $display("FAIL good_status: got done=%b err=%b busy=%b want 1 0 0", done, error, busy);
      end
   endtask

   task automatic test_ignore_in_done();
      int base;
      base = cap_addr.size();
      send_byte(8'h55);
      cmp_cnt++;
      if ({done, error, busy} !== 3'b100) begin
         err_cnt++;
         $display("FAIL idle_rx_ignored: got done=%b err=%b busy=%b want 1 0 0", done, error, busy);
      end
      // start and a byte together: the byte must be dropped
      start = 1'b1;
      send_byte(8'h00);
      start = 1'b0;
      cmp_cnt++;
      if ({done, error, busy} !== 3'b001) begin
         err_cnt++;
         $display("FAIL start_clears: got done=%b err=%b busy=%b want 0 0 1", done, error, busy);
      end
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22);
      pulse_start();
      send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h44);
      cmp_cnt++;
      if (cap_addr.size() - base != 1) begin
         err_cnt++;
         $display("FAIL ignore_write_count: got %0d want 1", cap_addr.size() - base);
      end else begin
         cmp_cnt++;
         if ({cap_addr[base], cap_data[base]} !== {32'h0, 32'h11223344}) begin
            err_cnt++;
            $display("FAIL ignore_word: got addr=%h data=%h want 0 11223344", cap_addr[base], cap_data[base]);
         end
      end
      cmp_cnt++;
      if ({done, error} !== 2'b10) begin
         err_cnt++;
         $display("FAIL ignore_status: got done=%b err=%b want 1 0", done, error);
      end
   endtask

   task automatic test_bad_checksum();
      int base;
      base = cap_addr.size();
      pulse_start();
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h3C); send_byte(8'h0D); send_byte(8'h40); send_byte(8'h00);
      send_byte(8'hAD); send_byte(8'hA0); send_byte(8'h00); send_byte(8'h08);
      send_byte(8'h75);
      cmp_cnt++;
      if (cap_addr.size() - base != 2) begin
         err_cnt++;
         $display("FAIL badcs_write_count: got %0d want 2", cap_addr.size() - base);
      end
      cmp_cnt++;
      if ({done, error, busy} !== 3'b010) begin
         err_cnt++;
         $display("FAIL badcs_status: got done=%b err=%b busy=%b want 0 1 0", done, error, busy);
      end
   endtask

   task automatic test_bad_length();
      logic [7:0] hi[2] = '{8'h00, 8'h01};
      logic [7:0] lo[2] = '{8'h00, 8'h01};
      int base;
      base = cap_addr.size();
      for (int i = 0; i < 2; i++) begin
         pulse_start();
         send_byte(hi[i]);
         send_byte(lo[i]);
         cmp_cnt++;
         if ({done, error, busy} !== 3'b010) begin
            err_cnt++;
            $display("FAIL badlen_%0d_status: got done=%b err=%b busy=%b want 0 1 0", i, done, error, busy);
         end
         send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      end
      cmp_cnt++;
      if (cap_addr.size() != base) begin
         err_cnt++;
         $display("FAIL badlen_no_write: got %0d writes want 0", cap_addr.size() - base);
      end
   endtask

   task automatic test_full_memory();
      int base;
      logic [7:0] cs;
      logic [31:0] w;
      int bad;
      base = cap_addr.size();
      cs = '0;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      for (int k = 0; k < 256; k++) begin
         w = {k[7:0], ~k[7:0], 8'hA5, k[7:0] ^ 8'h3C};
         for (int b = 3; b >= 0; b--) begin
            cs = cs ^ w[b*8 +: 8];
            send_byte(w[b*8 +: 8]);
         end
      end
      send_byte(cs);
      cmp_cnt++;
      if (cap_addr.size() - base != 256) begin
         err_cnt++;
         $display("FAIL full_write_count: got %0d want 256", cap_addr.size() - base);
      end else begin
         bad = 0;
         for (int k = 0; k < 256; k++) begin
            w = {k[7:0], ~k[7:0], 8'hA5, k[7:0] ^ 8'h3C};
            if ({cap_addr[base+k], cap_data[base+k]} !== {32'(k * 4), w}) bad++;
         end
         cmp_cnt++;
         if (bad != 0) begin
            err_cnt++;
            $display("FAIL full_words: %0d words wrong, want 0", bad);
         end
         cmp_cnt++;
         if (cap_addr[base+255] !== 32'h3FC) begin
            err_cnt++;
            $display("FAIL full_last_addr: got %h want 000003fc", cap_addr[base+255]);
         end
      end
      cmp_cnt++;
      if ({done, error, busy} !== 3'b100) begin
         err_cnt++;
         $display("FAIL full_status: got done=%b err=%b busy=%b want 1 0 0", done, error, busy);
      end
   endtask

   task automatic test_timeout();
      int base;
      logic seen_early;
      base = cap_addr.size();
      pulse_start();
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h3C);
      seen_early = 1'b0;
      for (int i = 1; i < int'(TB_TIMEOUT); i++) begin
         tick();
         if (error !== 1'b0 || busy !== 1'b1) seen_early = 1'b1;
      end
      cmp_cnt++;
      if (seen_early) begin
         err_cnt++;
         $display("FAIL timeout_early: error/busy changed before %0d cycles, want err=0 busy=1", TB_TIMEOUT);
      end
      tick();
      cmp_cnt++;
      if ({done, error, busy} !== 3'b010) begin
         err_cnt++;
         $display("FAIL timeout_status: got done=%b err=%b busy=%b want 0 1 0", done, error, busy);
      end
      cmp_cnt++;
      if (cap_addr.size() != base) begin
         err_cnt++;
         $display("FAIL timeout_no_write: got %0d writes want 0", cap_addr.size() - base);
      end
   endtask

   task automatic test_reset_mid_session();
      int base;
      base = cap_addr.size();
      pulse_start();
      send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
      reset = 1'b1;
      send_byte(8'hBE);
      reset = 1'b0;
      cmp_cnt++;
      if ({wr_en, wr_addr, wr_data, busy, done, error} !== 68'd0) begin
         err_cnt++;
         $display("FAIL midreset_outputs: got en=%b addr=%h data=%h busy=%b done=%b err=%b, want all 0",
                  wr_en, wr_addr, wr_data, busy, done, error);
      end
      send_byte(8'hEF);
      pulse_start();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      send_byte(8'h22);
      cmp_cnt++;
      if (cap_addr.size() - base != 1) begin
         err_cnt++;
         $display("FAIL midreset_write_count: got %0d want 1", cap_addr.size() - base);
      end else begin
         cmp_cnt++;
         if ({cap_addr[base], cap_data[base]} !== {32'h0, 32'hDEADBEEF}) begin
            err_cnt++;
            $display("FAIL midreset_word: got addr=%h data=%h want 0 deadbeef", cap_addr[base], cap_data[base]);
         end
      end
      cmp_cnt++;
      if ({done, error, busy} !== 3'b100) begin
         err_cnt++;
         $display("FAIL midreset_status: got done=%b err=%b busy=%b want 1 0 0", done, error, busy);
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_ignore_in_done();
      test_bad_checksum();
      test_bad_length();
      test_full_memory();
      test_timeout();
      test_reset_mid_session();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
